// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
// Hazard and flush scheduler for the 5-stage MIPS core. It sits beside the ID
// stage and decides, every cycle, whether to:
//   - stall the front end and insert an ID bubble (load-use or branch hazards),
//   - squash the fetched instruction after a taken beq, or
//   - run a multi-cycle exception drain that flushes IF, ID and EX.
// It also latches the exception cause and EPC, and keeps saturating counters
// for stall cycles and taken branches.
//
// Ports
//   clk, rst                      clock (rising edge) and async active-high reset
//   IFID_RegisterRs/Rt            source registers of the ID instruction
//   ID_UsesRt, ID_Branch, Iguales ID instruction qualifiers and branch compare
//   IDEX_* / EXMEM_*              producer info for the EX and MEM instructions
//   ExceptionCause                non-zero raises an exception this cycle
//   PCNext                        PC+1 of the ID instruction (becomes EPC)
//   PCWrite, IFID_Write           front-end update enables
//   ID_Bubble                     zero the ID controls going into ID/EX
//   IF_Flush, ID_Flush, EX_Flush  squash IF/ID, ID/EX, EX/MEM
//   BranchTaken                   select the branch target for the PC
//   ExcRedirect                   one-cycle pulse loading the exception vector
//   CauseReg, EPC, ExcOverrun     exception bookkeeping
//   StallCount, BranchCount       saturating performance counters
// -----------------------------------------------------------------------------
module hazard_sched #(
    parameter int REG_DIR_WIDTH = 3,
    parameter int PC_WIDTH      = 6,
    parameter int DRAIN_CYCLES  = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_DIR_WIDTH-1:0] IFID_RegisterRs,
    input  logic [REG_DIR_WIDTH-1:0] IFID_RegisterRt,
    input  logic                     ID_UsesRt,
    input  logic                     ID_Branch,
    input  logic                     Iguales,
    input  logic                     IDEX_MemRead,
    input  logic                     IDEX_RegWrite,
    input  logic [REG_DIR_WIDTH-1:0] IDEX_DestReg,
    input  logic                     EXMEM_MemRead,
    input  logic                     EXMEM_RegWrite,
    input  logic [REG_DIR_WIDTH-1:0] EXMEM_DestReg,
    input  logic [2:0]               ExceptionCause,
    input  logic [PC_WIDTH-1:0]      PCNext,
    output logic                     PCWrite,
    output logic                     IFID_Write,
    output logic                     ID_Bubble,
    output logic                     IF_Flush,
    output logic                     ID_Flush,
    output logic                     EX_Flush,
    output logic                     BranchTaken,
    output logic                     ExcRedirect,
    output logic [2:0]               CauseReg,
    output logic [PC_WIDTH-1:0]      EPC,
    output logic                     ExcOverrun,
    output logic [CNT_WIDTH-1:0]     StallCount,
    output logic [CNT_WIDTH-1:0]     BranchCount
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_r;
    logic [3:0]               drain_cnt_r;
    logic [2:0]               cause_r;
    logic [PC_WIDTH-1:0]      epc_r;
    logic                     overrun_r;
    logic [CNT_WIDTH-1:0]     stall_cnt_r;
    logic [CNT_WIDTH-1:0]     branch_cnt_r;

    logic                     exc_s;
    logic                     hazard_lu_s;
    logic                     hazard_br_s;
    logic                     stall_s;
    logic                     taken_s;

    // Register address equality; r0 is hard-wired zero and never a dependency.
    function automatic logic reg_match(input logic [REG_DIR_WIDTH-1:0] a,
                                       input logic [REG_DIR_WIDTH-1:0] b);
        return (a == b) && (a != {REG_DIR_WIDTH{1'b0}});
    endfunction

    // Hazard detection: load-use for any reader, plus extra cases for beq,
    // which resolves in ID and can only forward from the EX ALU result.
    always_comb begin
        exc_s       = (ExceptionCause != 3'd0);
        hazard_lu_s = IDEX_MemRead &
                      (reg_match(IDEX_DestReg, IFID_RegisterRs) |
                       (ID_UsesRt & reg_match(IDEX_DestReg, IFID_RegisterRt)));
        // beq always reads both rs and rt, so no ID_UsesRt qualifier here.
        hazard_br_s = ID_Branch &
                      ((IDEX_MemRead   & (reg_match(IDEX_DestReg,  IFID_RegisterRs) |
                                          reg_match(IDEX_DestReg,  IFID_RegisterRt))) |
                       (EXMEM_MemRead  & (reg_match(EXMEM_DestReg, IFID_RegisterRs) |
                                          reg_match(EXMEM_DestReg, IFID_RegisterRt))) |
                       (EXMEM_RegWrite & (reg_match(EXMEM_DestReg, IFID_RegisterRs) |
                                          reg_match(EXMEM_DestReg, IFID_RegisterRt))));
        stall_s     = hazard_lu_s | hazard_br_s;
        taken_s     = ID_Branch & Iguales;
    end

    // Zero-latency pipeline controls decoded from state and current inputs.
    always_comb begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        ID_Bubble   = 1'b0;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        EX_Flush    = 1'b0;
        BranchTaken = 1'b0;
        ExcRedirect = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_s) begin
                        PCWrite     = 1'b1;
                        IFID_Write  = 1'b1;
                        IF_Flush    = 1'b1;
                        ID_Flush    = 1'b1;
                        EX_Flush    = 1'b1;
                        ExcRedirect = 1'b1;
                    end else if (stall_s) begin
                        ID_Bubble   = 1'b1;
                    end else if (taken_s) begin
                        PCWrite     = 1'b1;
                        IFID_Write  = 1'b1;
                        IF_Flush    = 1'b1;
                        BranchTaken = 1'b1;
                    end else begin
                        PCWrite     = 1'b1;
                        IFID_Write  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Keep the pipe moving so younger work gets flushed out.
                    PCWrite    = 1'b1;
                    IFID_Write = 1'b1;
                    IF_Flush   = 1'b1;
                    ID_Flush   = 1'b1;
                    EX_Flush   = 1'b1;
                end
                default: begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                end
            endcase
        end
    end

    // Scheduler state, exception bookkeeping and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_RUN;
            drain_cnt_r  <= 4'd0;
            cause_r      <= 3'd0;
            epc_r        <= {PC_WIDTH{1'b0}};
            overrun_r    <= 1'b0;
            stall_cnt_r  <= {CNT_WIDTH{1'b0}};
            branch_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_s) begin
                        cause_r <= ExceptionCause;
                        epc_r   <= PCNext;
                        if (DRAIN_CYCLES > 1) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= DRAIN_LOAD;
                        end
                    end else if (stall_s) begin
                        if (stall_cnt_r != CNT_MAX) begin
                            stall_cnt_r <= stall_cnt_r + CNT_ONE;
                        end
                    end else if (taken_s) begin
                        if (branch_cnt_r != CNT_MAX) begin
                            branch_cnt_r <= branch_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A cause arriving mid-drain cannot be serviced; flag it only.
                    if (exc_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (drain_cnt_r <= 4'd1) begin
                        state_r     <= ST_RUN;
                        drain_cnt_r <= 4'd0;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    drain_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign CauseReg    = cause_r;
    assign EPC         = epc_r;
    assign ExcOverrun  = overrun_r;
    assign StallCount  = stall_cnt_r;
    assign BranchCount = branch_cnt_r;

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

    logic       clk;
    logic       rst;
    logic [2:0] rs, rt, idex_dest, exmem_dest;
    logic       uses_rt, id_branch, iguales;
    logic       idex_memread, idex_regwrite, exmem_memread, exmem_regwrite;
    logic [2:0] exc_cause;
    logic [5:0] pc_next;

    logic        pcwrite, ifid_write, id_bubble, if_flush, id_flush, ex_flush;
    logic        branch_taken, exc_redirect, exc_overrun;
    logic [2:0]  cause_reg;
    logic [5:0]  epc;
    logic [15:0] stall_count, branch_count;

    logic        pcwrite4, ifid_write4, id_bubble4, if_flush4, id_flush4, ex_flush4;
    logic        branch_taken4, exc_redirect4, exc_overrun4;
    logic [2:0]  cause_reg4;
    logic [5:0]  epc4;
    logic [3:0]  stall_count4, branch_count4;

    // Control vector: PCWrite IFID_Write ID_Bubble IF_Flush ID_Flush EX_Flush BranchTaken ExcRedirect
    logic [7:0] ctl;
    assign ctl = {pcwrite, ifid_write, id_bubble, if_flush, id_flush, ex_flush,
                  branch_taken, exc_redirect};

    localparam logic [7:0] C_ZERO  = 8'b0000_0000;
    localparam logic [7:0] C_IDLE  = 8'b1100_0000;
    localparam logic [7:0] C_STALL = 8'b0010_0000;
    localparam logic [7:0] C_TAKEN = 8'b1101_0010;
    localparam logic [7:0] C_EXC   = 8'b1101_1101;
    localparam logic [7:0] C_DRAIN = 8'b1101_1100;

    int n_checks = 0;
    int n_errors = 0;

    hazard_sched #(.REG_DIR_WIDTH(3), .PC_WIDTH(6), .DRAIN_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .IFID_RegisterRs(rs), .IFID_RegisterRt(rt), .ID_UsesRt(uses_rt),
        .ID_Branch(id_branch), .Iguales(iguales),
        .IDEX_MemRead(idex_memread), .IDEX_RegWrite(idex_regwrite), .IDEX_DestReg(idex_dest),
        .EXMEM_MemRead(exmem_memread), .EXMEM_RegWrite(exmem_regwrite), .EXMEM_DestReg(exmem_dest),
        .ExceptionCause(exc_cause), .PCNext(pc_next),
        .PCWrite(pcwrite), .IFID_Write(ifid_write), .ID_Bubble(id_bubble),
        .IF_Flush(if_flush), .ID_Flush(id_flush), .EX_Flush(ex_flush),
        .BranchTaken(branch_taken), .ExcRedirect(exc_redirect),
        .CauseReg(cause_reg), .EPC(epc), .ExcOverrun(exc_overrun),
        .StallCount(stall_count), .BranchCount(branch_count)
    );

    hazard_sched #(.REG_DIR_WIDTH(3), .PC_WIDTH(6), .DRAIN_CYCLES(2), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .IFID_RegisterRs(rs), .IFID_RegisterRt(rt), .ID_UsesRt(uses_rt),
        .ID_Branch(id_branch), .Iguales(iguales),
        .IDEX_MemRead(idex_memread), .IDEX_RegWrite(idex_regwrite), .IDEX_DestReg(idex_dest),
        .EXMEM_MemRead(exmem_memread), .EXMEM_RegWrite(exmem_regwrite), .EXMEM_DestReg(exmem_dest),
        .ExceptionCause(exc_cause), .PCNext(pc_next),
        .PCWrite(pcwrite4), .IFID_Write(ifid_write4), .ID_Bubble(id_bubble4),
        .IF_Flush(if_flush4), .ID_Flush(id_flush4), .EX_Flush(ex_flush4),
        .BranchTaken(branch_taken4), .ExcRedirect(exc_redirect4),
        .CauseReg(cause_reg4), .EPC(epc4), .ExcOverrun(exc_overrun4),
        .StallCount(stall_count4), .BranchCount(branch_count4)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        rs = 3'd0; rt = 3'd0; uses_rt = 1'b0; id_branch = 1'b0; iguales = 1'b0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dest = 3'd0;
        exmem_memread = 1'b0; exmem_regwrite = 1'b0; exmem_dest = 3'd0;
        exc_cause = 3'd0; pc_next = 6'd0;
    endtask

    // Leaves time at posedge+1 with reset released and idle inputs.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        exc_cause = 3'b101;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_ZERO);
        end
        n_checks++;
        if (cause_reg !== 3'd0 || epc !== 6'd0 || exc_overrun !== 1'b0) begin
            n_errors++; $display("FAIL reset_regs got cause=%0d epc=%0d ovr=%0d want 0 0 0",
                                 cause_reg, epc, exc_overrun);
        end
        n_checks++;
        if (stall_count !== 16'd0 || branch_count !== 16'd0) begin
            n_errors++; $display("FAIL reset_counts got %0d %0d want 0 0", stall_count, branch_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exc_cause = 3'd0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL reset_release_ctl got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dest = 3'd2; rs = 3'd2;
        #1;
        n_checks++;
        if (ctl !== C_STALL) begin
            n_errors++; $display("FAIL lu_stall got %b want %b", ctl, C_STALL);
        end
        next_cycle();
        // Bubble now in EX, load moved to MEM: a non-branch reader may proceed.
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dest = 3'd0;
        exmem_memread = 1'b1; exmem_regwrite = 1'b1; exmem_dest = 3'd2;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL lu_resume got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        n_checks++;
        if (stall_count !== 16'd1) begin
            n_errors++; $display("FAIL lu_count got %0d want 1", stall_count);
        end
        idle_inputs();
        idex_memread = 1'b1; idex_dest = 3'd0; rs = 3'd0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL lu_r0 got %b want %b", ctl, C_IDLE);
        end
        // rt only counts when the instruction reads it.
        idex_dest = 3'd5; rt = 3'd5; rs = 3'd1; uses_rt = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL lu_rt_unused got %b want %b", ctl, C_IDLE);
        end
        uses_rt = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_STALL) begin
            n_errors++; $display("FAIL lu_rt_used got %b want %b", ctl, C_STALL);
        end
    endtask

    task automatic test_branch_after_load();
        do_reset();
        id_branch = 1'b1; rs = 3'd1; rt = 3'd4; uses_rt = 1'b1; iguales = 1'b0;
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dest = 3'd4;
        #1;
        n_checks++;
        if (ctl !== C_STALL) begin
            n_errors++; $display("FAIL bl_stall1 got %b want %b", ctl, C_STALL);
        end
        next_cycle();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dest = 3'd0;
        exmem_memread = 1'b1; exmem_regwrite = 1'b1; exmem_dest = 3'd4;
        #1;
        n_checks++;
        if (ctl !== C_STALL) begin
            n_errors++; $display("FAIL bl_stall2 got %b want %b", ctl, C_STALL);
        end
        next_cycle();
        exmem_memread = 1'b0; exmem_regwrite = 1'b0; exmem_dest = 3'd0;
        iguales = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_TAKEN) begin
            n_errors++; $display("FAIL bl_taken got %b want %b", ctl, C_TAKEN);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL bl_after got %b want %b", ctl, C_IDLE);
        end
        n_checks++;
        if (stall_count !== 16'd2 || branch_count !== 16'd1) begin
            n_errors++; $display("FAIL bl_counts got %0d %0d want 2 1", stall_count, branch_count);
        end
    endtask

    task automatic test_branch_alu();
        do_reset();
        id_branch = 1'b1; rs = 3'd3; rt = 3'd6; uses_rt = 1'b1; iguales = 1'b0;
        idex_regwrite = 1'b1; idex_dest = 3'd3; idex_memread = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL alu_nottaken got %b want %b", ctl, C_IDLE);
        end
        iguales = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_TAKEN) begin
            n_errors++; $display("FAIL alu_taken got %b want %b", ctl, C_TAKEN);
        end
        // An ALU producer in MEM cannot be forwarded to ID.
        idex_regwrite = 1'b0; idex_dest = 3'd0;
        exmem_regwrite = 1'b1; exmem_dest = 3'd6;
        #1;
        n_checks++;
        if (ctl !== C_STALL) begin
            n_errors++; $display("FAIL alu_mem_stall got %b want %b", ctl, C_STALL);
        end
    endtask

    task automatic test_exception();
        do_reset();
        exc_cause = 3'b010; pc_next = 6'd17;
        #1;
        n_checks++;
        if (ctl !== C_EXC) begin
            n_errors++; $display("FAIL exc_detect got %b want %b", ctl, C_EXC);
        end
        next_cycle();
        n_checks++;
        if (cause_reg !== 3'd2 || epc !== 6'd17) begin
            n_errors++; $display("FAIL exc_latch got cause=%0d epc=%0d want 2 17", cause_reg, epc);
        end
        exc_cause = 3'b101; pc_next = 6'd9;
        #1;
        n_checks++;
        if (ctl !== C_DRAIN) begin
            n_errors++; $display("FAIL exc_drain got %b want %b", ctl, C_DRAIN);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (exc_overrun !== 1'b1 || cause_reg !== 3'd2 || epc !== 6'd17) begin
            n_errors++; $display("FAIL exc_overrun got ovr=%0d cause=%0d epc=%0d want 1 2 17",
                                 exc_overrun, cause_reg, epc);
        end
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_errors++; $display("FAIL exc_return got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_priority();
        do_reset();
        idex_memread = 1'b1; idex_dest = 3'd2; rs = 3'd2; exc_cause = 3'b011; pc_next = 6'd40;
        #1;
        n_checks++;
        if (ctl !== C_EXC) begin
            n_errors++; $display("FAIL prio_exc got %b want %b", ctl, C_EXC);
        end
        next_cycle();
        exc_cause = 3'd0; id_branch = 1'b1; iguales = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_DRAIN) begin
            n_errors++; $display("FAIL prio_drain_ignores got %b want %b", ctl, C_DRAIN);
        end
        next_cycle();
        n_checks++;
        if (stall_count !== 16'd0 || branch_count !== 16'd0 || cause_reg !== 3'd3
            || exc_overrun !== 1'b0) begin
            n_errors++; $display("FAIL prio_regs got st=%0d br=%0d cause=%0d ovr=%0d want 0 0 3 0",
                                 stall_count, branch_count, cause_reg, exc_overrun);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        idex_memread = 1'b1; idex_dest = 3'd7; rs = 3'd7;
        repeat (20) next_cycle();
        n_checks++;
        if (stall_count4 !== 4'd15) begin
            n_errors++; $display("FAIL sat_cnt4 got %0d want 15", stall_count4);
        end
        n_checks++;
        if (stall_count !== 16'd20) begin
            n_errors++; $display("FAIL sat_cnt16 got %0d want 20", stall_count);
        end
        // Asynchronous reset mid-stall clears without waiting for a clock edge.
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (stall_count !== 16'd0 || stall_count4 !== 4'd0 || ctl !== C_ZERO) begin
            n_errors++; $display("FAIL async_rst got %0d %0d %b want 0 0 %b",
                                 stall_count, stall_count4, ctl, C_ZERO);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_branch_alu();
        test_exception();
        test_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
